pipelined_cla_adder: RTL



---
 rtl/pipelined_cla_pkg.sv | 18 +
 rtl/cla_group.sv | 45 ++++
 rtl/pipelined_cla_adder.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipelined_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/sub unit.
// Stage payload fields are sized for operands up to 64 bits wide.
package pipelined_cla_pkg;

  function automatic int unsigned ng(input int unsigned width, input int unsigned group);
    return width / group;
  endfunction

  typedef struct packed {
    logic        valid;
    logic        carry;
    logic [63:0] a_hi;
    logic [63:0] b_hi;
    logic [63:0] sum_lo;
    logic        c_msb;
  } stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: every internal carry is
// expanded directly from g/p and the slice carry-in, not rippled.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built as one sum of products
  always_comb begin
    logic ci;
    logic pr;
    c    = '0;
    c[0] = cin;
    ci   = 1'b0;
    pr   = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      ci = g[i];
      pr = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        ci = ci | (pr & g[i-1-k]);
        pr = pr & p[i-1-k];
      end
      ci       = ci | (pr & cin);
      c[i+1]   = ci;
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit add/subtract: one GROUP-bit lookahead slice per stage,
// valid/ready handshake with a global stall driven by the output register.
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NG = ng(WIDTH, GROUP);

  stage_t      st      [NG];
  logic [63:0] a_src   [NG];
  logic [63:0] b_src   [NG];
  logic [63:0] sum_src [NG];
  logic [63:0] sum_nxt [NG];
  logic        c_src   [NG];
  logic        v_src   [NG];
  logic        stall;
  logic        zero_q;
  logic        unused_bits;

  assign stall    = st[NG-1].valid && !out_ready;
  assign in_ready = !stall;

  for (genvar s = 0; s < NG; s++) begin : g_stage
    logic [GROUP-1:0] gsum;
    logic             gcout;
    logic             gcmsb;
    stage_t           q;

    if (s == 0) begin : g_in
      assign a_src[s]   = 64'(in_a);
      assign b_src[s]   = 64'(in_sub ? ~in_b : in_b);
      assign c_src[s]   = in_sub | in_cin;
      assign v_src[s]   = in_valid;
      assign sum_src[s] = '0;
    end else begin : g_link
      assign a_src[s]   = st[s-1].a_hi;
      assign b_src[s]   = st[s-1].b_hi;
      assign c_src[s]   = st[s-1].carry;
      assign v_src[s]   = st[s-1].valid;
      assign sum_src[s] = st[s-1].sum_lo;
    end

    cla_group #(.GROUP(GROUP)) u_cla (
      .a     (a_src[s][GROUP-1:0]),
      .b     (b_src[s][GROUP-1:0]),
      .cin   (c_src[s]),
      .sum   (gsum),
      .cout  (gcout),
      .c_msb (gcmsb)
    );

    assign sum_nxt[s] = sum_src[s] | (64'(gsum) << (s * GROUP));

    // Payload loads only with a valid token so bubbles leave the outputs untouched
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (!stall) begin
        q.valid <= v_src[s];
        if (v_src[s]) begin
          q.carry  <= gcout;
          q.a_hi   <= a_src[s] >> GROUP;
          q.b_hi   <= b_src[s] >> GROUP;
          q.sum_lo <= sum_nxt[s];
          q.c_msb  <= gcmsb;
        end
      end
    end

    assign st[s] = q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (!stall && v_src[NG-1]) begin
      zero_q <= ~|sum_nxt[NG-1][WIDTH-1:0];
    end
  end

  assign out_valid = st[NG-1].valid;
  assign out_sum   = st[NG-1].sum_lo[WIDTH-1:0];
  assign out_cout  = st[NG-1].carry;
  assign out_ovf   = st[NG-1].c_msb ^ st[NG-1].carry;
  assign out_zero  = zero_q;

  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned i = 0; i < NG; i++) begin
      unused_bits = unused_bits ^ (^st[i]) ^ (^sum_nxt[i]);
    end
  end

endmodule
